// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module   : mdu
// Purpose  : Iterative radix-2 multiply / restoring-divide unit producing HI/LO
// Revision : 1.0 - initial release
// ============================================================================
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       MDUOp,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [2:0] c_OP_MULT  = 3'b001;
    localparam logic [2:0] c_OP_MULTU = 3'b010;
    localparam logic [2:0] c_OP_DIV   = 3'b011;
    localparam logic [2:0] c_OP_DIVU  = 3'b100;
    localparam logic [2:0] c_OP_MTHI  = 3'b101;
    localparam logic [2:0] c_OP_MTLO  = 3'b110;
    localparam int         c_CW       = $clog2(WIDTH) + 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [c_CW-1:0]   r_cnt;
    logic              r_is_div;
    logic              r_qsign;
    logic              r_rsign;
    logic              r_done;
    logic [WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]  r_acc_hi;
    logic [WIDTH-1:0]  r_acc_lo;

    logic              w_is_md;
    logic              w_signed;
    logic              w_div_op;
    logic              w_accept;
    logic [WIDTH-1:0]  w_abs_a;
    logic [WIDTH-1:0]  w_abs_b;
    logic [WIDTH:0]    w_mul_sum;
    logic [WIDTH-1:0]  w_mul_hi;
    logic [WIDTH-1:0]  w_mul_lo;
    logic [WIDTH:0]    w_trial;
    logic              w_ge;
    logic [WIDTH-1:0]  w_diff;
    logic [WIDTH-1:0]  w_div_hi;
    logic [WIDTH-1:0]  w_div_lo;
    logic [2*WIDTH-1:0] w_prod;

    assign w_signed = (MDUOp == c_OP_MULT) || (MDUOp == c_OP_DIV);
    assign w_div_op = (MDUOp == c_OP_DIV)  || (MDUOp == c_OP_DIVU);
    assign w_is_md  = start && (w_signed || w_div_op || (MDUOp == c_OP_MULTU));
    assign w_accept = (r_state == S_IDLE) && w_is_md;
    assign w_abs_a  = (w_signed && A[WIDTH-1]) ? -A : A;
    assign w_abs_b  = (w_signed && B[WIDTH-1]) ? -B : B;

    // Multiply step: conditional add into the upper half, then shift the pair right.
    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : '0);
    assign {w_mul_hi, w_mul_lo} = {w_mul_sum, r_acc_lo[WIDTH-1:1]};

    // Divide step: shift {rem,quot} left and keep the trial difference if it fits.
    assign w_trial  = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_ge     = (w_trial >= {1'b0, r_mcand});
    assign w_diff   = w_trial[WIDTH-1:0] - r_mcand;
    assign w_div_hi = w_ge ? w_diff : w_trial[WIDTH-1:0];
    assign w_div_lo = {r_acc_lo[WIDTH-2:0], w_ge};

    assign w_prod = {r_acc_hi, r_acc_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN:   if (r_cnt == c_LAST) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            r_done   <= 1'b0;
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            r_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_div <= w_div_op;
                        r_mcand  <= w_div_op ? w_abs_b : w_abs_a;
                        r_acc_lo <= w_div_op ? w_abs_a : w_abs_b;
                        r_acc_hi <= '0;
                        r_cnt    <= '0;
                        // Divide by zero keeps the all-ones quotient unsigned so LO ends 0xFFFFFFFF.
                        r_qsign  <= w_signed && (A[WIDTH-1] ^ B[WIDTH-1])
                                    && !(w_div_op && (B == '0));
                        r_rsign  <= w_signed && A[WIDTH-1];
                    end else if (start && (MDUOp == c_OP_MTHI)) begin
                        HI <= A;
                    end else if (start && (MDUOp == c_OP_MTLO)) begin
                        LO <= A;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_acc_hi <= w_div_hi;
                        r_acc_lo <= w_div_lo;
                    end else begin
                        r_acc_hi <= w_mul_hi;
                        r_acc_lo <= w_mul_lo;
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        HI <= r_rsign ? -r_acc_hi : r_acc_hi;
                        LO <= r_qsign ? -r_acc_lo : r_acc_lo;
                    end else begin
                        {HI, LO} <= r_qsign ? -w_prod : w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu
// Purpose  : Scoreboard bench for mdu against an arithmetic reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu;

    localparam logic [2:0] c_MULT  = 3'b001;
    localparam logic [2:0] c_MULTU = 3'b010;
    localparam logic [2:0] c_DIV   = 3'b011;
    localparam logic [2:0] c_DIVU  = 3'b100;
    localparam logic [2:0] c_MTHI  = 3'b101;
    localparam logic [2:0] c_MTLO  = 3'b110;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int tests = 0;
    int fails = 0;
    logic [63:0] q[$];
    logic        prev_done = 1'b0;

    mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .MDUOp(MDUOp), .start(start),
        .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {HI,LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     qv, rv, res;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = '0;
        case (op)
            c_MULT:  res = sa * sb;
            c_MULTU: res = ua * ub;
            c_DIV: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb; sr = sa % sb;
                    qv = sq; rv = sr;
                    res = {rv[31:0], qv[31:0]};
                end
            end
            c_DIVU: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub; ur = ua % ub;
                    qv = uq; rv = ur;
                    res = {rv[31:0], qv[31:0]};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Monitor: every done pulse pops one expected result.
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (q.size() == 0) begin
                tests++; fails++;
                $display("FAIL done_unexpected: got done=1 with empty scoreboard, required none");
            end else begin
                check("hilo", {HI, LO}, q.pop_front());
            end
            tests++;
            if (prev_done) begin
                fails++;
                $display("FAIL done_width: got done high 2 cycles, required 1");
            end
        end
        prev_done = done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Caller is at a negedge; start is accepted on the following posedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        MDUOp = op; A = a; B = b; start = 1'b1;
        if (op >= c_MULT && op <= c_DIVU) q.push_back(model(op, a, b));
        @(negedge clk);
        start = 1'b0;
        A = $urandom; B = $urandom; MDUOp = 3'($urandom);
    endtask

    task automatic wait_idle(output int n);
        logic [63:0] held;
        logic        ok;
        held = {HI, LO};
        ok = 1'b1;
        n = 0;
        while (busy && n < 60) begin
            if ({HI, LO} !== held) ok = 1'b0;
            n++;
            @(negedge clk);
        end
        check("hold_while_busy", {63'b0, ok}, 64'd1);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        issue(op, a, b);
        wait_idle(n);
        check("busy_cycles", 64'(n), 64'd33);
        check("done_seen", 64'(q.size()), 64'd0);
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] a);
        logic [31:0] hi0, lo0;
        hi0 = HI; lo0 = LO;
        MDUOp = op; A = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mt_hi", {32'b0, HI}, {32'b0, (op == c_MTHI) ? a : hi0});
        check("mt_lo", {32'b0, LO}, {32'b0, (op == c_MTLO) ? a : lo0});
        check("mt_flags", {62'b0, busy, done}, 64'd0);
    endtask

    initial begin
        int          n;
        logic [2:0]  op;
        logic [31:0] ra, rb;
        rst = 1'b1; start = 1'b0; MDUOp = '0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {busy, done, 30'b0, HI ^ LO, 1'b0}, 64'd0);
        check("reset_hilo", {HI, LO}, 64'd0);
        rst = 1'b0;

        run_op(c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
        run_op(c_MULT, 32'hFFFF_FFF9, 32'd3);
        check("mult_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(c_MULTU, 32'hFFFF_FFF9, 32'd3);
        check("multu_neg", {HI, LO}, 64'h0000_0002_FFFF_FFEB);
        run_op(c_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(c_DIVU, 32'd7, 32'd2);
        check("divu_small", {HI, LO}, 64'h0000_0001_0000_0003);
        run_op(c_DIVU, 32'h1234, 32'd0);
        check("divu_by0", {HI, LO}, 64'h0000_1234_FFFF_FFFF);
        run_op(c_DIV, 32'hFFFF_FF00, 32'd0);
        check("div_by0", {HI, LO}, 64'hFFFF_FF00_FFFF_FFFF);
        run_op(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf", {HI, LO}, 64'h0000_0000_8000_0000);

        // Start during busy must be ignored.
        issue(c_MULT, 32'h0001_2345, 32'hFFFF_0F0F);
        repeat (9) @(negedge clk);
        MDUOp = c_DIVU; A = 32'd99; B = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        check("ignored_start", 64'(q.size()), 64'd0);
        repeat (40) @(negedge clk);
        check("no_second_op", {63'b0, busy}, 64'd0);
        move_to(c_MTHI, 32'hDEAD_BEEF);
        move_to(c_MTLO, 32'hCAFE_F00D);

        // Reset aborts an operation in flight.
        issue(c_DIV, 32'h7654_3210, 32'd13);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(q.pop_back());
        check("abort_flags", {62'b0, busy, done}, 64'd0);
        check("abort_hilo", {HI, LO}, 64'd0);
        repeat (40) @(negedge clk);
        run_op(c_DIVU, 32'd100, 32'd7);
        check("divu_after_abort", {HI, LO}, 64'h0000_0002_0000_000E);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) rb = rb >> $urandom_range(8, 28);
            if (op >= c_MULT && op <= c_DIVU) run_op(op, ra, rb);
            else if (op == c_MTHI || op == c_MTLO) move_to(op, ra);
            else move_to(op, ra);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit that sits beside the ALU in the execute stage of the single-cycle MIPS datapath. It takes the same register operands the ALU consumes and produces the HI/LO pair. The HI/LO pair feeds the writeback mux (mfhi/mflo) next to the ALU result. A multi-cycle start/busy/done handshake stalls the PC while an operation runs.

## Interface

Parameters:
- WIDTH, 32, operand and HI/LO width. The iteration count equals WIDTH.

Ports:
- clk  in  1  system clock; every state change occurs on the rising edge.
- rst  in  1  reset, synchronous and active-high. It clears all state on the next rising edge.
- A  in  WIDTH  operand rs: dividend or multiplicand.
- B  in  WIDTH  operand rt: divisor or multiplier.
- MDUOp  in  3  operation select: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NOP.
- start  in  1  qualifies MDUOp for one cycle.
- busy  out  1  high while an iterative operation is in progress. Control stalls the PC and register write on busy.
- done  out  1  one-cycle pulse on the cycle in which HI/LO first show a new multiply/divide result.
- HI  out  WIDTH  HI register. Holds the product upper half or the remainder.
- LO  out  WIDTH  LO register. Holds the product lower half or the quotient.

## Operation

- FSM states: IDLE, RUN, FIX. busy = (state != IDLE).
- In IDLE, start with MULT/MULTU/DIV/DIVU:
  - Latch the operand magnitudes. For signed ops, take |A| and |B|; for unsigned ops, use them raw.
  - Latch the sign flags: quotient/product sign = sA^sB; remainder sign = sA. Unsigned ops have zero sign flags.
  - Clear the 6-bit iteration counter and go to RUN.
- In IDLE, start with MTHI/MTLO: HI<=A or LO<=A at that edge; no busy, no done.
- In IDLE, start with NOP: ignored.
- Start while busy is ignored in all cases; the operand latches are not disturbed.
- RUN, multiply: shift-add, radix-2. Each cycle, if the multiplier LSB is 1, add the multiplicand into the upper half of a 2*WIDTH accumulator (with carry), then shift right 1. Runs exactly WIDTH cycles.
- RUN, divide: restoring division. Each cycle, shift {rem,quot} left 1, trial-subtract the divisor from rem (WIDTH+1-bit compare), and keep the result with quotient bit = 1 if it is non-negative. Runs exactly WIDTH cycles.
- Leave RUN when counter = WIDTH-1, going to FIX.
- FIX:
  - Apply the sign fix. Multiply: negate the 64-bit product if its sign flag is set. Divide: negate the quotient and remainder per their flags.
  - Write HI/LO, set done, return to IDLE.
- Divide by zero (B==0, signed or unsigned) runs the full latency, then HI = A (original), LO = 32'hFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. This is the natural wrap; no trap.
- HI/LO hold their value indefinitely outside the FIX and MTHI/MTLO edges.

## Timing

- Reset values: state = IDLE, busy = 0, done = 0, HI = 0, LO = 0, counter = 0.
- Edge E0 (start accepted): busy = 1 after E0.
- Edges E1..E32 are the RUN iterations; E32 moves the FSM to FIX.
- Edge E33 (FIX) writes HI/LO, sets done = 1 and busy = 0.
- Result latency: HI/LO are valid 33 cycles after the accepting edge. busy is high for exactly 33 cycles.
- done is high for exactly one cycle, after E33. It clears at E34 regardless of start.
- A new start may be accepted at E34, the first cycle with busy = 0 after the operation. Back-to-back operations therefore take 34 cycles each.
- MTHI/MTLO latency: 1 edge. done stays 0.
- rst during RUN or FIX: the operation aborts, HI/LO = 0, busy = 0 and done = 0 after that edge, with no partial result written. rst has priority over start on the same edge.
- Operands A and B may change after E0 without affecting the result.

## Test plan

- Reset, then MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> busy for 33 cycles, done pulse once, HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=-7 (0xFFFFFFF9) B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFEB.
- DIV A=-7 B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=7 B=2 -> LO=3, HI=1.
- DIVU A=0x1234 B=0 -> HI=0x00001234, LO=0xFFFFFFFF after 33 cycles. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start MULT and pulse start with DIVU at cycle 10 -> second start ignored, MULT result correct. Then MTHI A=0xDEADBEEF while idle -> HI=0xDEADBEEF next edge, done stays 0.
- Start DIV, assert rst at cycle 15 -> busy = 0, HI = LO = 0 and done = 0 after the edge. Next DIVU 100/7 -> LO=14, HI=2.
